// File: rtl/rx_payload_q_pkg.sv
// Shared RX payload-queue definitions: pointer type, admission FSM states and
// the circular-queue full test used by the admission stage.
package rx_payload_q_pkg;

    localparam int FLOW_ID_W           = 8;
    localparam int RX_PAYLOAD_Q_SIZE_W = 3;
    localparam int PAYLOAD_ENTRY_W     = 32;
    localparam int PTR_MSB             = RX_PAYLOAD_Q_SIZE_W;

    // Queue pointer with one extra wrap bit above the index bits.
    typedef logic [RX_PAYLOAD_Q_SIZE_W:0] rx_q_ptr_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_QUERY     = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_ENQ       = 3'd3,
        ST_STATUS    = 3'd4
    } admit_state_e;

    // Everything remembered about the single packet in flight.
    typedef struct packed {
        logic [FLOW_ID_W-1:0]       flowid;
        logic [PAYLOAD_ENTRY_W-1:0] data;
        rx_q_ptr_t                  tail;
        logic                       accepted;
    } admit_ctx_t;

    // Full when the index bits match but the pointers are a lap apart.
    function automatic logic rx_q_full(input rx_q_ptr_t tail, input rx_q_ptr_t head);
        return (tail[PTR_MSB] != head[PTR_MSB]) &&
               (tail[PTR_MSB-1:0] == head[PTR_MSB-1:0]);
    endfunction

endpackage

// File: rtl/rx_pkt_payload_admit.sv
// RX payload admission: queries a flow's queue pointers, enqueues at the tail
// when there is room, otherwise drops, and reports one status per packet.
module rx_pkt_payload_admit
    import rx_payload_q_pkg::*;
#(
    parameter int DROP_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       pkt_req_val,
    input  logic [FLOW_ID_W-1:0]       pkt_req_flowid,
    input  logic [PAYLOAD_ENTRY_W-1:0] pkt_req_data,
    output logic                       pkt_req_rdy,

    output logic                       q_full_req_val,
    output logic [FLOW_ID_W-1:0]       q_full_req_flowid,
    input  logic                       q_full_req_rdy,

    input  logic                       q_full_resp_val,
    input  rx_q_ptr_t                  q_full_resp_tail_index,
    input  rx_q_ptr_t                  q_full_resp_head_index,
    output logic                       q_full_resp_rdy,

    output logic                       enqueue_pkt_req_val,
    output logic [FLOW_ID_W-1:0]       enqueue_pkt_req_flowid,
    output rx_q_ptr_t                  enqueue_pkt_req_index,
    output logic [PAYLOAD_ENTRY_W-1:0] enqueue_pkt_req_data,
    input  logic                       enqueue_pkt_req_rdy,

    output logic                       pkt_status_val,
    output logic [FLOW_ID_W-1:0]       pkt_status_flowid,
    output logic                       pkt_status_accepted,
    input  logic                       pkt_status_rdy,

    output logic [DROP_CNT_W-1:0]      drop_cnt
);

    admit_state_e state;
    admit_state_e state_nxt;
    admit_ctx_t   ctx;
    logic         resp_full;
    logic         admit_fire;
    logic         resp_fire;

    assign resp_full  = rx_q_full(q_full_resp_tail_index, q_full_resp_head_index);
    assign admit_fire = (state == ST_IDLE) && pkt_req_val;
    assign resp_fire  = (state == ST_WAIT_RESP) && q_full_resp_val;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (pkt_req_val)         state_nxt = ST_QUERY;
            ST_QUERY:     if (q_full_req_rdy)      state_nxt = ST_WAIT_RESP;
            ST_WAIT_RESP: if (q_full_resp_val)     state_nxt = resp_full ? ST_STATUS : ST_ENQ;
            ST_ENQ:       if (enqueue_pkt_req_rdy) state_nxt = ST_STATUS;
            ST_STATUS:    if (pkt_status_rdy)      state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // Handshake qualifiers decode purely from the registered state; rdy toward
    // the RX pipe is withheld while reset is held so no packet is half-taken.
    always_comb begin
        pkt_req_rdy         = (state == ST_IDLE) && !rst;
        q_full_req_val      = (state == ST_QUERY);
        q_full_resp_rdy     = (state == ST_WAIT_RESP);
        enqueue_pkt_req_val = (state == ST_ENQ);
        pkt_status_val      = (state == ST_STATUS);
    end

    // NOTE: the capture registers and counter are few and flat, so they are all
    // reset; an in-flight packet leaves nothing behind after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctx      <= '0;
            drop_cnt <= '0;
        end else begin
            if (admit_fire) begin
                ctx.flowid <= pkt_req_flowid;
                ctx.data   <= pkt_req_data;
            end
            if (resp_fire) begin
                ctx.tail     <= q_full_resp_tail_index;
                ctx.accepted <= !resp_full;
                if (resp_full && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

    assign q_full_req_flowid      = ctx.flowid;
    assign enqueue_pkt_req_flowid = ctx.flowid;
    assign enqueue_pkt_req_index  = ctx.tail;
    assign enqueue_pkt_req_data   = ctx.data;
    assign pkt_status_flowid      = ctx.flowid;
    assign pkt_status_accepted    = ctx.accepted;

endmodule

// File: tb/tb_rx_pkt_payload_admit.sv
// Directed bench for rx_pkt_payload_admit with a scoreboard of expected
// enqueue commands and per-packet statuses.
module tb_rx_pkt_payload_admit;
    import rx_payload_q_pkg::*;

    typedef struct {
        logic [FLOW_ID_W-1:0]       flowid;
        rx_q_ptr_t                  index;
        logic [PAYLOAD_ENTRY_W-1:0] data;
    } enq_t;

    typedef struct {
        logic [FLOW_ID_W-1:0] flowid;
        logic                 accepted;
    } stat_t;

    logic                       clk;
    logic                       rst;
    logic                       pkt_req_val;
    logic [FLOW_ID_W-1:0]       pkt_req_flowid;
    logic [PAYLOAD_ENTRY_W-1:0] pkt_req_data;
    logic                       pkt_req_rdy;
    logic                       q_full_req_val;
    logic [FLOW_ID_W-1:0]       q_full_req_flowid;
    logic                       q_full_req_rdy;
    logic                       q_full_resp_val;
    rx_q_ptr_t                  q_full_resp_tail_index;
    rx_q_ptr_t                  q_full_resp_head_index;
    logic                       q_full_resp_rdy;
    logic                       enqueue_pkt_req_val;
    logic [FLOW_ID_W-1:0]       enqueue_pkt_req_flowid;
    rx_q_ptr_t                  enqueue_pkt_req_index;
    logic [PAYLOAD_ENTRY_W-1:0] enqueue_pkt_req_data;
    logic                       enqueue_pkt_req_rdy;
    logic                       pkt_status_val;
    logic [FLOW_ID_W-1:0]       pkt_status_flowid;
    logic                       pkt_status_accepted;
    logic                       pkt_status_rdy;
    logic [15:0]                drop_cnt;

    // Second instance with a 2-bit counter shares all inputs.
    logic                       d2_pkt_req_rdy;
    logic                       d2_q_full_req_val;
    logic [FLOW_ID_W-1:0]       d2_q_full_req_flowid;
    logic                       d2_q_full_resp_rdy;
    logic                       d2_enqueue_pkt_req_val;
    logic [FLOW_ID_W-1:0]       d2_enqueue_pkt_req_flowid;
    rx_q_ptr_t                  d2_enqueue_pkt_req_index;
    logic [PAYLOAD_ENTRY_W-1:0] d2_enqueue_pkt_req_data;
    logic                       d2_pkt_status_val;
    logic [FLOW_ID_W-1:0]       d2_pkt_status_flowid;
    logic                       d2_pkt_status_accepted;
    logic [1:0]                 d2_drop_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int q_hs = 0;
    int e_hs = 0;
    int s_hs = 0;
    enq_t  enq_q[$];
    stat_t stat_q[$];
    enq_t  mon_e;
    stat_t mon_s;
    logic [15:0] exp_drop16 = '0;
    logic [1:0]  exp_drop2  = '0;

    rx_pkt_payload_admit #(.DROP_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .pkt_req_val(pkt_req_val), .pkt_req_flowid(pkt_req_flowid),
        .pkt_req_data(pkt_req_data), .pkt_req_rdy(pkt_req_rdy),
        .q_full_req_val(q_full_req_val), .q_full_req_flowid(q_full_req_flowid),
        .q_full_req_rdy(q_full_req_rdy),
        .q_full_resp_val(q_full_resp_val), .q_full_resp_tail_index(q_full_resp_tail_index),
        .q_full_resp_head_index(q_full_resp_head_index), .q_full_resp_rdy(q_full_resp_rdy),
        .enqueue_pkt_req_val(enqueue_pkt_req_val), .enqueue_pkt_req_flowid(enqueue_pkt_req_flowid),
        .enqueue_pkt_req_index(enqueue_pkt_req_index), .enqueue_pkt_req_data(enqueue_pkt_req_data),
        .enqueue_pkt_req_rdy(enqueue_pkt_req_rdy),
        .pkt_status_val(pkt_status_val), .pkt_status_flowid(pkt_status_flowid),
        .pkt_status_accepted(pkt_status_accepted), .pkt_status_rdy(pkt_status_rdy),
        .drop_cnt(drop_cnt)
    );

    rx_pkt_payload_admit #(.DROP_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .pkt_req_val(pkt_req_val), .pkt_req_flowid(pkt_req_flowid),
        .pkt_req_data(pkt_req_data), .pkt_req_rdy(d2_pkt_req_rdy),
        .q_full_req_val(d2_q_full_req_val), .q_full_req_flowid(d2_q_full_req_flowid),
        .q_full_req_rdy(q_full_req_rdy),
        .q_full_resp_val(q_full_resp_val), .q_full_resp_tail_index(q_full_resp_tail_index),
        .q_full_resp_head_index(q_full_resp_head_index), .q_full_resp_rdy(d2_q_full_resp_rdy),
        .enqueue_pkt_req_val(d2_enqueue_pkt_req_val), .enqueue_pkt_req_flowid(d2_enqueue_pkt_req_flowid),
        .enqueue_pkt_req_index(d2_enqueue_pkt_req_index), .enqueue_pkt_req_data(d2_enqueue_pkt_req_data),
        .enqueue_pkt_req_rdy(enqueue_pkt_req_rdy),
        .pkt_status_val(d2_pkt_status_val), .pkt_status_flowid(d2_pkt_status_flowid),
        .pkt_status_accepted(d2_pkt_status_accepted), .pkt_status_rdy(pkt_status_rdy),
        .drop_cnt(d2_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bench's own notion of a full queue: pointers differ only in the wrap bit.
    function automatic logic model_full(input rx_q_ptr_t tail, input rx_q_ptr_t head);
        rx_q_ptr_t wrap_only;
        wrap_only = 4'b1000;
        return (tail ^ head) == wrap_only;
    endfunction

    // Scoreboard side: handshakes are sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (q_full_req_val && q_full_req_rdy) q_hs++;
            if (enqueue_pkt_req_val && enqueue_pkt_req_rdy) begin
                e_hs++;
                if (enq_q.size() == 0) begin
                    check("enq_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_e = enq_q.pop_front();
                    check("enq_flowid", 64'(enqueue_pkt_req_flowid), 64'(mon_e.flowid));
                    check("enq_index",  64'(enqueue_pkt_req_index),  64'(mon_e.index));
                    check("enq_data",   64'(enqueue_pkt_req_data),   64'(mon_e.data));
                end
            end
            if (pkt_status_val && pkt_status_rdy) begin
                s_hs++;
                if (stat_q.size() == 0) begin
                    check("status_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_s = stat_q.pop_front();
                    check("status_flowid",   64'(pkt_status_flowid),   64'(mon_s.flowid));
                    check("status_accepted", 64'(pkt_status_accepted), 64'(mon_s.accepted));
                end
            end
        end
    end

    task automatic send_pkt(input logic [FLOW_ID_W-1:0] flow, input logic [PAYLOAD_ENTRY_W-1:0] data,
                            input rx_q_ptr_t head, input rx_q_ptr_t tail,
                            input int q_stall, input int e_stall, input int s_stall);
        logic full;
        int   cyc, qn, en, sn, q0, e0, s0, exp_lat;
        bit   done, seen;
        enq_t  e;
        stat_t s;
        full    = model_full(tail, head);
        exp_lat = full ? 3 + q_stall : 4 + q_stall + e_stall;
        if (!full) begin
            e.flowid = flow; e.index = tail; e.data = data;
            enq_q.push_back(e);
        end
        s.flowid = flow; s.accepted = !full;
        stat_q.push_back(s);
        if (full) begin
            exp_drop16++;
            if (exp_drop2 != 2'b11) exp_drop2++;
        end
        q0 = q_hs; e0 = e_hs; s0 = s_hs;
        q_full_req_rdy      = (q_stall == 0);
        enqueue_pkt_req_rdy = (e_stall == 0);
        pkt_status_rdy      = (s_stall == 0);
        // Pointer response is held valid throughout; outside WAIT_RESP it must be ignored.
        q_full_resp_head_index = head;
        q_full_resp_tail_index = tail;
        q_full_resp_val        = 1'b1;
        pkt_req_flowid = flow;
        pkt_req_data   = data;
        pkt_req_val    = 1'b1;
        for (int n = 0; n < 20 && !pkt_req_rdy; n++) step();
        check("admit_rdy", 64'(pkt_req_rdy), 64'(1));
        step();
        pkt_req_val = 1'b0;
        cyc = 1; qn = 0; en = 0; sn = 0; done = 0; seen = 0;
        while (!done && cyc < 60) begin
            check("admit_rdy_busy", 64'(pkt_req_rdy), 64'(0));
            if (q_full_req_val) begin
                qn++;
                check("query_flowid", 64'(q_full_req_flowid), 64'(flow));
                q_full_req_rdy = (qn > q_stall);
            end else begin
                q_full_req_rdy = (q_stall == 0);
            end
            if (full) check("drop_no_enq", 64'(enqueue_pkt_req_val), 64'(0));
            if (enqueue_pkt_req_val) begin
                en++;
                check("enq_index_hold", 64'(enqueue_pkt_req_index), 64'(tail));
                enqueue_pkt_req_rdy = (en > e_stall);
            end else begin
                enqueue_pkt_req_rdy = (e_stall == 0);
            end
            if (pkt_status_val) begin
                sn++;
                if (!seen) check("status_latency", 64'(cyc), 64'(exp_lat));
                seen = 1;
                pkt_status_rdy = (sn > s_stall);
                done = pkt_status_rdy;
            end else begin
                pkt_status_rdy = (s_stall == 0);
            end
            step();
            cyc++;
        end
        check("status_done", 64'(done), 64'(1));
        q_full_resp_val = 1'b0;
        check("query_hs_count",  64'(q_hs - q0), 64'(1));
        check("enq_hs_count",    64'(e_hs - e0), 64'(full ? 0 : 1));
        check("status_hs_count", 64'(s_hs - s0), 64'(1));
        check("drop_cnt",        64'(drop_cnt),    64'(exp_drop16));
        check("drop_cnt_w2",     64'(d2_drop_cnt), 64'(exp_drop2));
        check("back_to_idle",    64'(pkt_req_rdy), 64'(1));
    endtask

    initial begin
        rst = 1'b1;
        pkt_req_val = 1'b0; pkt_req_flowid = '0; pkt_req_data = '0;
        q_full_req_rdy = 1'b1; q_full_resp_val = 1'b0;
        q_full_resp_tail_index = '0; q_full_resp_head_index = '0;
        enqueue_pkt_req_rdy = 1'b1; pkt_status_rdy = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_q_val",    64'(q_full_req_val),      64'(0));
        check("rst_resp_rdy", 64'(q_full_resp_rdy),     64'(0));
        check("rst_enq_val",  64'(enqueue_pkt_req_val), 64'(0));
        check("rst_stat_val", 64'(pkt_status_val),      64'(0));
        check("rst_pkt_rdy",  64'(pkt_req_rdy),         64'(1));
        check("rst_drop_cnt", 64'(drop_cnt),            64'(0));

        // Empty, full, and both sides of the wrap boundary.
        send_pkt(8'd5,  32'h0000_00AB, 4'b0000, 4'b0000, 0, 0, 0);
        send_pkt(8'd7,  32'h1234_5678, 4'b0010, 4'b1010, 0, 0, 0);
        send_pkt(8'd9,  32'hCAFE_0001, 4'b0111, 4'b1110, 0, 0, 0);
        send_pkt(8'd9,  32'hCAFE_0002, 4'b0110, 4'b1110, 0, 0, 0);
        // Backpressure on every downstream handshake.
        send_pkt(8'd3,  32'hDEAD_BEEF, 4'b0001, 4'b0100, 3, 3, 3);
        send_pkt(8'd4,  32'h0BAD_F00D, 4'b0101, 4'b1101, 2, 0, 1);
        for (int i = 0; i < 4; i++) begin
            rx_q_ptr_t h, t;
            h = 4'($urandom_range(0, 15));
            t = ($urandom_range(0, 1) == 1) ? (h ^ 4'b1000) : 4'($urandom_range(0, 15));
            send_pkt(8'($urandom_range(0, 255)), $urandom, h, t, 0, 0, 0);
        end

        // Reset while the enqueue command is being held valid.
        q_full_resp_head_index = 4'b0000;
        q_full_resp_tail_index = 4'b0011;
        q_full_resp_val = 1'b1;
        q_full_req_rdy = 1'b1;
        enqueue_pkt_req_rdy = 1'b0;
        pkt_req_flowid = 8'd11;
        pkt_req_data = 32'h5555_AAAA;
        pkt_req_val = 1'b1;
        step();
        pkt_req_val = 1'b0;
        for (int n = 0; n < 10 && !enqueue_pkt_req_val; n++) step();
        check("pre_rst_enq_val", 64'(enqueue_pkt_req_val), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_full_resp_val = 1'b0;
        #1;
        exp_drop16 = '0;
        exp_drop2  = '0;
        check("mid_rst_q_val",    64'(q_full_req_val),      64'(0));
        check("mid_rst_enq_val",  64'(enqueue_pkt_req_val), 64'(0));
        check("mid_rst_stat_val", 64'(pkt_status_val),      64'(0));
        check("mid_rst_pkt_rdy",  64'(pkt_req_rdy),         64'(1));
        check("mid_rst_drop_cnt", 64'(drop_cnt),            64'(0));
        check("mid_rst_idx",      64'(enqueue_pkt_req_index), 64'(0));
        send_pkt(8'd12, 32'h7777_0001, 4'b0100, 4'b0101, 0, 0, 0);

        // Five consecutive drops: the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            send_pkt(8'(20 + i), 32'(i), 4'b0011, 4'b1011, 0, 0, 0);
        end
        check("sat_drop_cnt_w2", 64'(d2_drop_cnt), 64'(3));
        check("sat_drop_cnt_16", 64'(drop_cnt),    64'(5));

        step();
        check("enq_sb_empty",  64'(enq_q.size()),  64'(0));
        check("stat_sb_empty", 64'(stat_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
